// File: rtl/kmap_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep controller.
// Optional stop-on-first-error build: KMAP_SWEEP_STOP_ON_ERR_EN.
package kmap_sweep_pkg;

  localparam int X_W_DEF        = 4;
  localparam int SETTLE_CYC_DEF = 1;
  localparam int CNT_MAX_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  function automatic logic [CNT_MAX_W-1:0] cnt_inc(
    input logic [CNT_MAX_W-1:0] c,
    input logic                 hit
  );
    return c + {{(CNT_MAX_W-1){1'b0}}, hit};
  endfunction

endpackage

// File: rtl/kmap_settle_timer.sv
// Per-code settle counter; tc_o marks the sample cycle.
// Used by kmap_sweep_ctrl (KMAP_SWEEP_STOP_ON_ERR_EN agnostic).
module kmap_settle_timer
  import kmap_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic clk,
  input  logic areset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == 4'(SETTLE_CYC - 1));

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Exhaustive x sweep of a function unit against a golden truth vector.
// Define KMAP_SWEEP_STOP_ON_ERR_EN to end on first mismatch (adds fail_idx).
module kmap_sweep_ctrl
  import kmap_sweep_pkg::*;
#(
  parameter int X_W        = X_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              start,
  input  logic [2**X_W-1:0] golden,
  output logic [X_W-1:0]    x,
  output logic              x_valid,
  input  logic              f,
  output logic              busy,
  output logic              done,
  output logic [2**X_W-1:0] truth,
  output logic [2**X_W-1:0] mismatch,
  output logic [X_W:0]      err_cnt,
  output logic              pass
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
  ,
  output logic [X_W-1:0]    fail_idx
`endif
);

  localparam int N   = 2**X_W;
  localparam int E_W = X_W + 1;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [N-1:0]   gold_q, gold_d;
  logic [N-1:0]   truth_q, truth_d;
  logic [N-1:0]   mis_q, mis_d;
  logic [E_W-1:0] err_q, err_d;
  logic           pass_q, pass_d;
  logic           tc, hit, last, sweep_end;

  kmap_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk     (clk),
    .areset_n(areset_n),
    .clr_i   ((state_q != DRIVE) | tc),
    .en_i    (state_q == DRIVE),
    .tc_o    (tc)
  );

  assign hit  = f ^ gold_q[x_q];
  assign last = (x_q == X_W'(N - 1));

`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
  logic [X_W-1:0] fidx_q, fidx_d;
  assign sweep_end = tc & (last | hit);
  assign fail_idx  = fidx_q;
`else
  assign sweep_end = tc & last;
`endif

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sweep_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    x_valid = (state_q == DRIVE);
  end

  always_comb begin
    x_d     = x_q;
    gold_d  = gold_q;
    truth_d = truth_q;
    mis_d   = mis_q;
    err_d   = err_q;
    pass_d  = pass_q;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
    fidx_d  = fidx_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        gold_d  = golden;
        truth_d = '0;
        mis_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
        x_d     = '0;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
        fidx_d  = '0;
`endif
      end
      DRIVE: if (tc) begin
        truth_d[x_q] = f;
        mis_d[x_q]   = hit;
        err_d = E_W'(cnt_inc(CNT_MAX_W'(err_q), hit));
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
        if (hit) fidx_d = x_q;
`endif
        if (sweep_end) pass_d = (err_d == '0);
        else           x_d    = x_q + X_W'(1);
      end
      DONE:    x_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      x_q     <= '0;
      gold_q  <= '0;
      truth_q <= '0;
      mis_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
      fidx_q  <= '0;
`endif
    end else begin
      x_q     <= x_d;
      gold_q  <= gold_d;
      truth_q <= truth_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
      fidx_q  <= fidx_d;
`endif
    end
  end

  assign x        = x_q;
  assign truth    = truth_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed + random sweeps of kmap_sweep_ctrl against a truth-table model.
// Honours KMAP_SWEEP_STOP_ON_ERR_EN when defined.
module tb_kmap_sweep_ctrl;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] golden = '0;
  logic [15:0] F = '0;

  logic [3:0]  x1, x3;
  logic        xv1, xv3, busy1, busy3, done1, done3;
  logic [15:0] tr1, tr3, mm1, mm3;
  logic [4:0]  ec1, ec3;
  logic        pass1, pass3;
  logic        f1, f3;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
  logic [3:0]  fi1, fi3;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign f1 = F[x1];
  always @(posedge clk) f3 <= F[x3];

  kmap_sweep_ctrl #(.X_W(4), .SETTLE_CYC(1)) u_dut (
    .clk(clk), .areset_n(areset_n), .start(start & ~sel),
    .golden(golden), .x(x1), .x_valid(xv1), .f(f1),
    .busy(busy1), .done(done1), .truth(tr1), .mismatch(mm1),
    .err_cnt(ec1), .pass(pass1)
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
    , .fail_idx(fi1)
`endif
  );

  kmap_sweep_ctrl #(.X_W(4), .SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .areset_n(areset_n), .start(start & sel),
    .golden(golden), .x(x3), .x_valid(xv3), .f(f3),
    .busy(busy3), .done(done3), .truth(tr3), .mismatch(mm3),
    .err_cnt(ec3), .pass(pass3)
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
    , .fail_idx(fi3)
`endif
  );

  wire [3:0]  x_m    = sel ? x3 : x1;
  wire        xv_m   = sel ? xv3 : xv1;
  wire        busy_m = sel ? busy3 : busy1;
  wire        done_m = sel ? done3 : done1;
  wire [15:0] tr_m   = sel ? tr3 : tr1;
  wire [15:0] mm_m   = sel ? mm3 : mm1;
  wire [4:0]  ec_m   = sel ? ec3 : ec1;
  wire        pass_m = sel ? pass3 : pass1;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
  wire [3:0]  fi_m   = sel ? fi3 : fi1;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from the truth-table definition.
  task automatic model(input logic [15:0] fn, input logic [15:0] gold,
                       input int s, output logic [15:0] et,
                       output logic [15:0] em, output int ee,
                       output int ecyc, output int efi);
    logic [15:0] m;
    m    = fn ^ gold;
    et   = fn;
    em   = m;
    ee   = $countones(m);
    ecyc = 16 * s;
    efi  = 0;
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
    if (m != 16'h0) begin
      int k;
      k = 0;
      while (!m[k]) k++;
      et   = fn & 16'((32'h1 << (k + 1)) - 1);
      em   = 16'h1 << k;
      ee   = 1;
      ecyc = (k + 1) * s;
      efi  = k;
    end
`endif
  endtask

  task automatic sweep(input logic s3, input logic [15:0] fn,
                       input logic [15:0] gold, input bit disturb,
                       input string tag);
    logic [15:0] et, em;
    int ee, ecyc, efi, j, s;
    bit seq_ok;
    s = s3 ? 3 : 1;
    model(fn, gold, s, et, em, ee, ecyc, efi);
    sel = s3;
    F = fn;
    golden = gold;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    seq_ok = 1'b1;
    while (!done_m && j < 200) begin
      if (x_m !== 4'(j / s) || xv_m !== 1'b1 || busy_m !== 1'b1)
        seq_ok = 1'b0;
      if (disturb && j == 5) begin
        start = 1'b1;
        golden = ~gold;
      end
      if (disturb && j == 7) start = 1'b0;
      @(negedge clk);
      j++;
    end
    check({tag, " x_seq"}, 32'(seq_ok), 32'd1);
    check({tag, " done_cyc"}, j, ecyc);
    check({tag, " done"}, 32'(done_m), 32'd1);
    check({tag, " busy_done"}, 32'(busy_m), 32'd1);
    check({tag, " xv_done"}, 32'(xv_m), 32'd0);
    check({tag, " truth"}, 32'(tr_m), 32'(et));
    check({tag, " mismatch"}, 32'(mm_m), 32'(em));
    check({tag, " err_cnt"}, 32'(ec_m), ee);
    check({tag, " pass"}, 32'(pass_m), 32'(ee == 0));
`ifdef KMAP_SWEEP_STOP_ON_ERR_EN
    check({tag, " fail_idx"}, 32'(fi_m), efi);
`endif
    @(negedge clk);
    check({tag, " done_clr"}, 32'(done_m), 32'd0);
    check({tag, " busy_clr"}, 32'(busy_m), 32'd0);
    check({tag, " x_idle"}, 32'(x_m), 32'd0);
    check({tag, " truth_hold"}, 32'(tr_m), 32'(et));
    check({tag, " pass_hold"}, 32'(pass_m), 32'(ee == 0));
    golden = gold;
  endtask

  initial begin
    int j;
    bit saw_done;
    logic [15:0] rf, rm;
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    check("rst x", 32'(x1), 0);
    check("rst xv", 32'(xv1), 0);
    check("rst busy", 32'(busy1), 0);
    check("rst done", 32'(done1), 0);
    check("rst truth", 32'(tr1), 0);
    check("rst mis", 32'(mm1), 0);
    check("rst err", 32'(ec1), 0);
    check("rst pass", 32'(pass1), 0);

    sweep(1'b0, 16'hD073, 16'hD073, 1'b0, "match");
    sweep(1'b0, 16'hD073, 16'hD072, 1'b0, "onebit");
    sweep(1'b0, 16'hD073, 16'h2F8C, 1'b0, "allbits");
    sweep(1'b1, 16'hD073, 16'hD073, 1'b0, "settle3");
    sweep(1'b0, 16'hD073, 16'hD073, 1'b1, "disturb");

    sel = 1'b0;
    F = 16'hD073;
    golden = 16'hD073;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (x1 !== 4'd7 && j < 50) begin
      @(negedge clk);
      j++;
    end
    check("rst_mid reach7", 32'(x1), 32'd7);
    areset_n = 1'b0;
    #1;
    check("rst_mid x", 32'(x1), 0);
    check("rst_mid busy", 32'(busy1), 0);
    check("rst_mid xv", 32'(xv1), 0);
    check("rst_mid truth", 32'(tr1), 0);
    check("rst_mid err", 32'(ec1), 0);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done1 !== 1'b0) saw_done = 1'b1;
    end
    check("rst_mid no_done", 32'(saw_done), 0);
    areset_n = 1'b1;
    sweep(1'b0, 16'hD073, 16'hD073, 1'b0, "post_rst");

    for (int i = 0; i < 8; i++) begin
      rf = 16'($urandom);
      rm = 16'($urandom & $urandom & $urandom);
      if (i == 0) rm = 16'h0;
      sweep(1'($urandom_range(0, 1)), rf, rf ^ rm, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/kmap_sweep_ctrl.md
Name: kmap_sweep_ctrl

Overview:
Sequencer that exhaustively drives a 4-input combinational function unit (x -> f) through all input codes. It captures each f result into a truth-table vector and compares it against a golden truth vector. It reports per-code mismatches, an error count and a pass flag. It sits beside the function unit as its self-check/characterisation controller, with a start/done handshake to the host.

Parameters:
X_W, 4, function input width; number of codes N = 2**X_W.
SETTLE_CYC, 1, cycles each x code is held before f is sampled; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
areset_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; honoured only in IDLE
golden  input  2**X_W  expected truth vector, bit i = expected f for x=i; latched on accepted start
x  output  X_W  code driven to function unit
x_valid  output  1  high while x carries a code under test
f  input  1  function unit output
busy  output  1  high from accepted start until DONE is left
done  output  1  one-cycle pulse at sweep end
truth  output  2**X_W  captured f per code
mismatch  output  2**X_W  bit i = truth[i] XOR golden[i]; valid when done=1
err_cnt  output  X_W+1  number of mismatching codes (0..N)
pass  output  1  err_cnt==0; updated with done, held until next start

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE. x=0, x_valid=0, busy=0, done=0, truth=0, mismatch=0, err_cnt=0, pass=0, settle counter=0. Reset mid-sweep aborts immediately; no done pulse is produced.
- FSM states: IDLE, DRIVE, DONE.
- IDLE: on start=1 at an edge:
  - latch golden;
  - clear truth, mismatch and err_cnt;
  - x=0, x_valid=1, busy=1, settle counter=0;
  - go to DRIVE.
- DRIVE: x held constant for SETTLE_CYC cycles. At the edge where counter==SETTLE_CYC-1:
  - truth[x] <= f;
  - mismatch[x] <= f ^ golden_q[x];
  - err_cnt increments if they differ.
  - Then, if x==N-1: go to DONE and set x_valid=0. Otherwise x <= x+1 and counter <= 0.
  - In all other DRIVE cycles the counter increments.
  - x never wraps past N-1.
- DONE: done=1 and pass=(err_cnt==0) for exactly one cycle, busy still 1. Next edge goes to IDLE with busy=0 and x=0.
- Timing: if start is accepted at edge E0, the last sample occurs at edge E0+N*SETTLE_CYC. done is high in the cycle following that edge.
- start while busy or in DONE is ignored; it is not queued.
- start held high continuously re-triggers a new sweep on the first IDLE cycle after DONE.
- golden changes after acceptance have no effect on the current sweep.
- truth, mismatch, err_cnt and pass hold their values in IDLE until the next accepted start.
- err_cnt width X_W+1 so the all-mismatch case reports N (16 for default) without overflow.

Optional Feature:
Macro KMAP_SWEEP_STOP_ON_ERR_EN.
- Defined:
  - adds output fail_idx [X_W-1:0];
  - on the first sample with a mismatch, the FSM goes straight to DONE with err_cnt=1, pass=0, fail_idx=x of the failing code, and truth/mismatch bits for later codes left 0;
  - fail_idx resets to 0 and is cleared on start.
- Not defined: no fail_idx port; the full sweep always runs.

Decomposition:
- Package kmap_sweep_pkg holds:
  - state enum {IDLE, DRIVE, DONE};
  - localparam defaults for X_W and SETTLE_CYC;
  - helper function popcount-free increment width X_W+1.
- One natural sub-module: kmap_settle_timer. A counter with a clear and a terminal-count output at SETTLE_CYC-1, instantiated once. The FSM, x register and result registers stay in kmap_sweep_ctrl.

Test Plan:
- Bench function model with truth vector 16'hD073, golden=16'hD073, SETTLE_CYC=1, start pulse -> x steps 0..15 one per cycle; done high in the 17th cycle after the start edge; truth=16'hD073, mismatch=0, err_cnt=0, pass=1.
- Same model, golden=16'hD072 -> mismatch=16'h0001, err_cnt=1, pass=0; with KMAP_SWEEP_STOP_ON_ERR_EN: done 2 cycles after the start edge, fail_idx=0.
- golden=~16'hD073 (16'h2F8C) -> mismatch=16'hFFFF, err_cnt=16, pass=0.
- SETTLE_CYC=3, model with f registered (1-cycle lag) -> each x held 3 cycles; truth=16'hD073; done 49 cycles after the start edge.
- start re-pulsed during DRIVE and golden toggled mid-sweep -> no restart, results unchanged from the first-scenario values.
- areset_n pulled low during x=7 -> all outputs 0 immediately, no done; after release a new start completes normally with pass=1.
